// File: rtl/brightness_keys.sv
// brightness_keys: push-button front end for the brightness stage.
//
// Synchronises and debounces two raw active-low buttons, then issues one
// single-cycle inc/dec pulse per press. Holding a key auto-repeats the pulse.
// Pressing both keys together issues a single bright_rst pulse. Steps past
// level 0 or 15 are never requested.
//
// Optional feature: define BRIGHT_HEX_EN to add the hex_n port. It carries a
// registered, active-low 7-segment decode of level_in.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_up_n   raw "brighter" button, active-low, asynchronous
//   key_dn_n   raw "darker" button, active-low, asynchronous
//   level_in   current brightness level fed back from the brightness stage
//   inc        single-cycle request to raise the level by one
//   dec        single-cycle request to lower the level by one
//   bright_rst single-cycle request to return the level to 8
//   keys_held  debounced pressed state {up,dn}, active-high
//   hex_n      (BRIGHT_HEX_EN only) segment pattern g..a of level_in, active-low
module brightness_keys #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic [3:0] level_in,
`ifdef BRIGHT_HEX_EN
  output logic [6:0] hex_n,
`endif
  output logic       inc,
  output logic       dec,
  output logic       bright_rst,
  output logic [1:0] keys_held
);

  localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StRepeat,
    StBoth,
    StWaitRel
  } state_e;

  // Bit 1 = up key, bit 0 = down key throughout.
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]            keys_held_q, keys_held_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic                  dir_q, dir_d;  // 1 = up key owns the FSM
  logic                  inc_q, inc_d;
  logic                  dec_q, dec_d;
  logic                  bright_rst_q, bright_rst_d;
  logic                  step;
  logic                  rst_req;
  logic [1:0]            raw_press;

  // Synchroniser and debounce
  always_comb begin
    sync1_d   = {key_up_n, key_dn_n};
    sync2_d   = sync1_q;
    raw_press = ~sync2_q;
    for (int i = 0; i < 2; i++) begin
      press_d[i]  = press_q[i];
      db_cnt_d[i] = '0;
      if (raw_press[i] != press_q[i]) begin
        // Accept the new level only after an unbroken run of differing samples.
        if (db_cnt_q[i] >= DbLast) begin
          press_d[i] = ~press_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    keys_held_d = press_q;
  end

  // Press / repeat / both-keys FSM, driven from the registered held state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    step    = 1'b0;
    rst_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (keys_held_q == 2'b11) begin
          state_d = StBoth;
          rst_req = 1'b1;
        end else if (keys_held_q != 2'b00) begin
          dir_d   = keys_held_q[1];
          step    = 1'b1;
          state_d = StDelay;
        end
      end
      StDelay, StRepeat: begin
        // Release wins over a due repeat pulse.
        if (!keys_held_q[dir_q]) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (keys_held_q[~dir_q]) begin
          state_d = StBoth;
          rst_req = 1'b1;
          timer_d = '0;
        end else if (timer_q >= ((state_q == StDelay) ? DelayLast : PeriodLast)) begin
          step    = 1'b1;
          timer_d = '0;
          state_d = StRepeat;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StBoth: begin
        timer_d = '0;
        state_d = StWaitRel;
      end
      StWaitRel: begin
        timer_d = '0;
        if (keys_held_q == 2'b00) begin
          state_d = StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase

    // Saturation only masks the request; the FSM keeps its schedule.
    inc_d        = step & dir_d & (level_in != 4'hF);
    dec_d        = step & ~dir_d & (level_in != 4'h0);
    bright_rst_d = rst_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      press_q      <= '0;
      db_cnt_q     <= '0;
      keys_held_q  <= '0;
      state_q      <= StIdle;
      timer_q      <= '0;
      dir_q        <= 1'b0;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      bright_rst_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      press_q      <= press_d;
      db_cnt_q     <= db_cnt_d;
      keys_held_q  <= keys_held_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      bright_rst_q <= bright_rst_d;
    end
  end

  assign inc        = inc_q;
  assign dec        = dec_q;
  assign bright_rst = bright_rst_q;
  assign keys_held  = keys_held_q;

`ifdef BRIGHT_HEX_EN
  logic [6:0] hex_q, hex_d;

  // Segment order g..a, active-low.
  always_comb begin
    unique case (level_in)
      4'h0:    hex_d = 7'h40;
      4'h1:    hex_d = 7'h79;
      4'h2:    hex_d = 7'h24;
      4'h3:    hex_d = 7'h30;
      4'h4:    hex_d = 7'h19;
      4'h5:    hex_d = 7'h12;
      4'h6:    hex_d = 7'h02;
      4'h7:    hex_d = 7'h78;
      4'h8:    hex_d = 7'h00;
      4'h9:    hex_d = 7'h10;
      4'hA:    hex_d = 7'h08;
      4'hB:    hex_d = 7'h03;
      4'hC:    hex_d = 7'h46;
      4'hD:    hex_d = 7'h21;
      4'hE:    hex_d = 7'h06;
      default: hex_d = 7'h0E;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q <= 7'h7F;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_n = hex_q;
`endif

endmodule

// File: doc/brightness_keys.md
Name: brightness_keys

Overview:
- Front-end controller that produces the `inc`/`dec` level-change pulses and the brightness reset request for the brightness stage.
- Takes two raw active-low push-buttons (KEY inputs on the board) and synchronises and debounces them.
- Emits exactly one single-cycle pulse per press, plus auto-repeat pulses while a key is held; pressing both keys together requests a level reset.
- Reads the brightness stage's current level back, so it never requests a step past 0 or 15.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a key change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles a key is held after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses.
- CNT_W, 25, width of the debounce and repeat counters; must hold the largest of the three values above.

Ports:
- clk  input  1  pixel/system clock.
- rst_n  input  1  asynchronous, active-low reset.
- key_up_n  input  1  raw "brighter" button, active-low, asynchronous to clk.
- key_dn_n  input  1  raw "darker" button, active-low, asynchronous to clk.
- level_in  input  4  current brightness level, fed back from the brightness stage.
- inc  output  1  single-cycle request to raise the level by one.
- dec  output  1  single-cycle request to lower the level by one.
- bright_rst  output  1  single-cycle request to return the level to 8.
- keys_held  output  2  debounced pressed state {up,dn}, active-high.
- hex_n  output  7  active-low 7-segment pattern of level_in; present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous): all flops clear.
  - inc, dec and bright_rst are 0; keys_held is 2'b00; FSM is in IDLE; counters are 0.
  - Synchroniser flops reset to 1 (released).
- Synchroniser: two flops per key, so raw input to sync output takes 2 cycles.
- Debounce, per key:
  - Counter resets whenever sync equals the debounced state; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- keys_held is the inverted debounced state, registered.
- FSM states and transitions (one shared FSM, one repeat timer):
  - IDLE:
    - Exactly one key newly pressed: pulse that key and go to DELAY, timer = 0.
    - Both keys pressed in the same cycle: go to BOTH.
  - DELAY:
    - Held key released: go to IDLE.
    - Other key becomes pressed: go to BOTH.
    - Timer reaches REPEAT_DELAY-1: pulse, timer = 0, go to REPEAT.
  - REPEAT:
    - Timer reaches REPEAT_PERIOD-1: pulse, timer = 0.
    - Release: go to IDLE.
    - Both keys pressed: go to BOTH.
  - BOTH: assert bright_rst for exactly one cycle on entry, then go to WAIT_REL.
  - WAIT_REL: stay until both keys are debounced-released, then go to IDLE. No pulses are issued here.
- Pulse outputs:
  - inc and dec are registered: they assert the cycle after the FSM decision and last exactly one cycle.
  - inc and dec are never high together; bright_rst is never high together with either.
- Saturation gating:
  - An inc pulse is suppressed when level_in == 4'hF.
  - A dec pulse is suppressed when level_in == 4'h0.
  - The FSM and timer advance regardless of gating.
- Latency: raw key held low from cycle N (first sampled) gives an inc/dec pulse at cycle N+DEBOUNCE_CYCLES+3.
- Reset mid-hold: on release of rst_n with a key still physically held:
  - The debouncer accepts the press after DEBOUNCE_CYCLES.
  - This is treated as a new press and produces a pulse.
- Counter width: every counter saturates at its terminal value and never wraps.

Optional Feature:
- Macro: BRIGHT_HEX_EN.
- Defined:
  - hex_n port exists.
  - It is a registered hex decode of level_in (0-F standard DE1-SoC segment map, active-low, segment order g..a).
  - It is 7'h7F during reset and updates 1 cycle after level_in changes.
- Undefined: hex_n port and its logic are omitted; all other behaviour is identical.

Test Plan:
(Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.)
- Single press: key_up_n low for 10 cycles from cycle 0, level_in=8 -> exactly one inc pulse at cycle 7; no dec; keys_held=2'b10 from cycle 6.
- Glitch rejection: key_dn_n low for 3 cycles -> no dec, keys_held stays 00.
- Auto-repeat: key_dn_n held for 60 cycles, level_in=5 -> dec at cycles 7, 27, 35, 43, 51, 59; nothing after release.
- Saturation: key_up_n held 40 cycles with level_in=4'hF -> no inc pulses, FSM still reaches REPEAT; key_dn_n with level_in=0 -> no dec.
- Both keys pressed in the same cycle -> a single bright_rst pulse at cycle 7, no inc/dec; release one key while the other stays held -> no pulses until both are released and one is pressed again.
- Async reset mid-repeat: rst_n low for 1 cycle while key held -> outputs clear immediately; one new inc at DEBOUNCE_CYCLES+3 after rst_n rises; with BRIGHT_HEX_EN defined, hex_n=7'h7F during reset and the decode of level_in=4'hA one cycle after.
